// File: rtl/truth_table_scanner_if.sv
// Stimulus/capture bus between the truth-table scanner and its controller.
// The bench or control logic is the master; the function under test drives y.
interface truth_table_scanner_if;
  logic        start;
  logic [15:0] expected;
  logic [3:0]  vec;
  logic        y;
  logic        busy;
  logic        done;
  logic [15:0] table_out;
  logic        pass;
  logic [4:0]  mismatch_cnt;
  logic [3:0]  first_fail;

  modport master (
    output start, expected, y,
    input  vec, busy, done, table_out, pass, mismatch_cnt, first_fail
  );

  modport slave (
    input  start, expected, y,
    output vec, busy, done, table_out, pass, mismatch_cnt, first_fail
  );
endinterface

// File: rtl/truth_table_scanner.sv
// Walks every input vector of a 3/4-input Boolean function, samples its output
// after a settle window, and grades the captured truth table against an expected one.
module truth_table_scanner #(
  parameter int unsigned NVARS  = 4,
  parameter int unsigned SETTLE = 2
) (
  input logic                  clk,
  input logic                  rst,
  truth_table_scanner_if.slave bus
);

  localparam int unsigned NumVecs   = 1 << NVARS;
  localparam logic [3:0]  LastVec   = 4'(NumVecs - 1);
  localparam logic [3:0]  SettleMax = 4'(SETTLE);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} stateT;

  stateT       state, stateNxt;
  logic [3:0]  vecQ, vecNxt;
  logic [3:0]  settleQ, settleNxt;
  logic [15:0] expQ, expNxt;
  logic [15:0] tableQ, tableNxt;
  logic [4:0]  mismQ, mismNxt;
  logic [3:0]  firstQ, firstNxt;
  logic        passQ, passNxt;
  logic        busyQ, busyNxt;
  logic        doneQ, doneNxt;

  // State and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      vecQ    <= '0;
      settleQ <= '0;
      expQ    <= '0;
      tableQ  <= '0;
      mismQ   <= '0;
      firstQ  <= '0;
      passQ   <= 1'b0;
      busyQ   <= 1'b0;
      doneQ   <= 1'b0;
    end else begin
      state   <= stateNxt;
      vecQ    <= vecNxt;
      settleQ <= settleNxt;
      expQ    <= expNxt;
      tableQ  <= tableNxt;
      mismQ   <= mismNxt;
      firstQ  <= firstNxt;
      passQ   <= passNxt;
      busyQ   <= busyNxt;
      doneQ   <= doneNxt;
    end
  end

  // Next-state and next-output logic; busy/done are computed one edge ahead
  always_comb begin
    stateNxt  = state;
    vecNxt    = vecQ;
    settleNxt = settleQ;
    expNxt    = expQ;
    tableNxt  = tableQ;
    mismNxt   = mismQ;
    firstNxt  = firstQ;
    passNxt   = passQ;
    busyNxt   = 1'b0;
    doneNxt   = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          stateNxt  = APPLY;
          expNxt    = bus.expected;
          tableNxt  = '0;
          mismNxt   = '0;
          firstNxt  = '0;
          passNxt   = 1'b0;
          vecNxt    = '0;
          settleNxt = '0;
          busyNxt   = 1'b1;
        end else begin
          stateNxt = IDLE;
        end
      end

      APPLY: begin
        busyNxt = 1'b1;
        if (settleQ < SettleMax) begin
          settleNxt = settleQ + 4'd1;
        end else begin
          tableNxt[vecQ] = bus.y;
          if (bus.y != expQ[vecQ]) begin
            mismNxt = mismQ + 5'd1;
            if (mismQ == 5'd0) firstNxt = vecQ;
          end
          if (vecQ == LastVec) begin
            stateNxt = DONE;
            vecNxt   = '0;
            busyNxt  = 1'b0;
            doneNxt  = 1'b1;
            passNxt  = (mismNxt == 5'd0);
          end else begin
            vecNxt    = vecQ + 4'd1;
            settleNxt = '0;
          end
        end
      end

      default: stateNxt = IDLE;
    endcase
  end

  assign bus.vec          = vecQ;
  assign bus.busy         = busyQ;
  assign bus.done         = doneQ;
  assign bus.table_out    = tableQ;
  assign bus.pass         = passQ;
  assign bus.mismatch_cnt = mismQ;
  assign bus.first_fail   = firstQ;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench for truth_table_scanner: a 4-input scanner on Y4 and a
// 3-input scanner on Y2, each graded against an independent reference model.
module tb_truth_table_scanner;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   nCompared = 0;
  int   nMismatch = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] tbl;
    logic        pass;
    logic [4:0]  cnt;
    logic [3:0]  ff;
    int          doneCyc;
  } resultT;

  resultT q4[$];
  resultT q3[$];
  resultT r4, r3;

  truth_table_scanner_if bus4 ();
  truth_table_scanner_if bus3 ();

  // Functions under test
  function automatic logic y4Fn(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return (b & d) | (a & c) | (~b & ~d) | (a & b);
  endfunction

  assign bus4.y = y4Fn(bus4.vec);
  assign bus3.y = ~bus3.vec[1];

  truth_table_scanner #(.NVARS(4), .SETTLE(2)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  truth_table_scanner #(.NVARS(3), .SETTLE(0)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatch++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [15:0] table4();
    logic [15:0] t = '0;
    for (int i = 0; i < 16; i++) t[i] = y4Fn(4'(i));
    return t;
  endfunction

  function automatic logic [15:0] table3();
    logic [15:0] t = '0;
    logic [3:0]  v;
    for (int i = 0; i < 8; i++) begin
      v = 4'(i);
      t[i] = ~v[1];
    end
    return t;
  endfunction

  function automatic resultT model(input logic [15:0] tbl, input logic [15:0] exp,
                                   input int nv, input int doneCyc);
    resultT r;
    r.tbl = '0;
    r.cnt = '0;
    r.ff  = '0;
    for (int i = 0; i < (1 << nv); i++) begin
      r.tbl[i] = tbl[i];
      if (tbl[i] != exp[i]) begin
        if (r.cnt == 5'd0) r.ff = 4'(i);
        r.cnt = r.cnt + 5'd1;
      end
    end
    r.pass    = (r.cnt == 5'd0);
    r.doneCyc = doneCyc;
    return r;
  endfunction

  // Scoreboard pop on each done pulse
  always @(negedge clk) begin
    if (bus4.done) begin
      if (q4.size() == 0) checkEq("spurious_done4", 32'd1, 32'd0);
      else begin
        r4 = q4.pop_front();
        checkEq("done_cyc4", cyc, r4.doneCyc);
        checkEq("table4", 32'(bus4.table_out), 32'(r4.tbl));
        checkEq("pass4", 32'(bus4.pass), 32'(r4.pass));
        checkEq("mcnt4", 32'(bus4.mismatch_cnt), 32'(r4.cnt));
        checkEq("ffail4", 32'(bus4.first_fail), 32'(r4.ff));
        checkEq("vec4_done", 32'(bus4.vec), 32'd0);
      end
    end
    if (bus3.done) begin
      if (q3.size() == 0) checkEq("spurious_done3", 32'd1, 32'd0);
      else begin
        r3 = q3.pop_front();
        checkEq("done_cyc3", cyc, r3.doneCyc);
        checkEq("table3", 32'(bus3.table_out), 32'(r3.tbl));
        checkEq("pass3", 32'(bus3.pass), 32'(r3.pass));
        checkEq("mcnt3", 32'(bus3.mismatch_cnt), 32'(r3.cnt));
        checkEq("ffail3", 32'(bus3.first_fail), 32'(r3.ff));
      end
    end
    if (bus3.busy) checkEq("vec3_msb", 32'(bus3.vec[3]), 32'd0);
  end

  task automatic startScan4(input logic [15:0] exp, input bit push);
    @(negedge clk);
    bus4.expected = exp;
    bus4.start    = 1'b1;
    if (push) q4.push_back(model(table4(), exp, 4, cyc + 1 + 16 * 3));
    @(negedge clk);
    bus4.start = 1'b0;
    checkEq("busy4_start", 32'(bus4.busy), 32'd1);
    checkEq("vec4_start", 32'(bus4.vec), 32'd0);
  endtask

  task automatic startScan3(input logic [15:0] exp);
    @(negedge clk);
    bus3.expected = exp;
    bus3.start    = 1'b1;
    q3.push_back(model(table3(), exp, 3, cyc + 1 + 8 * 1));
    @(negedge clk);
    bus3.start = 1'b0;
    checkEq("busy3_start", 32'(bus3.busy), 32'd1);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 400 && (q4.size() != 0 || q3.size() != 0); i++) @(negedge clk);
    @(negedge clk);
    if (q4.size() != 0 || q3.size() != 0) begin
      checkEq("drain_timeout", 32'(q4.size() + q3.size()), 32'd0);
      q4.delete();
      q3.delete();
    end
  endtask

  initial begin
    int accept;
    rst           = 1'b1;
    bus4.start    = 1'b0;
    bus4.expected = '0;
    bus3.start    = 1'b0;
    bus3.expected = '0;
    repeat (3) @(negedge clk);
    checkEq("rst_busy", 32'(bus4.busy), 32'd0);
    checkEq("rst_done", 32'(bus4.done), 32'd0);
    checkEq("rst_vec", 32'(bus4.vec), 32'd0);
    checkEq("rst_table", 32'(bus4.table_out), 32'd0);
    checkEq("rst_pass", 32'(bus4.pass), 32'd0);
    checkEq("rst_mcnt", 32'(bus4.mismatch_cnt), 32'd0);
    checkEq("rst_ffail", 32'(bus4.first_fail), 32'd0);
    rst = 1'b0;

    startScan4(16'hFDA5, 1'b1);
    waitDrain();
    repeat (3) @(negedge clk);
    checkEq("hold_table4", 32'(bus4.table_out), 32'h0000FDA5);
    checkEq("hold_pass4", 32'(bus4.pass), 32'd1);

    startScan3(16'h0033);
    waitDrain();

    startScan4(16'hFDA4, 1'b1);
    waitDrain();
    startScan4(16'h0000, 1'b1);
    waitDrain();

    // Upper expected bits are ignored by the 3-input scanner
    startScan3(16'hFF33);
    waitDrain();
    for (int k = 0; k < 3; k++) begin
      startScan4(16'($urandom), 1'b1);
      waitDrain();
    end
    startScan3(16'($urandom));
    waitDrain();

    // Start re-pulsed while busy must not disturb timing or results
    startScan4(16'hFDA5, 1'b1);
    repeat (10) @(negedge clk);
    bus4.expected = 16'h0000;
    bus4.start    = 1'b1;
    @(negedge clk);
    bus4.start    = 1'b0;
    waitDrain();

    // Start held through DONE chains a second scan with no idle cycle
    @(negedge clk);
    bus4.expected = 16'hFDA5;
    bus4.start    = 1'b1;
    accept        = cyc + 1;
    q4.push_back(model(table4(), 16'hFDA5, 4, accept + 48));
    q4.push_back(model(table4(), 16'hFDA5, 4, accept + 48 + 1 + 48));
    for (int i = 0; i < 100 && !bus4.done; i++) @(negedge clk);
    if (!bus4.done) checkEq("b2b_timeout", 32'd0, 32'd1);
    @(negedge clk);
    checkEq("b2b_busy", 32'(bus4.busy), 32'd1);
    checkEq("b2b_done", 32'(bus4.done), 32'd0);
    bus4.start = 1'b0;
    waitDrain();

    // Reset mid-scan at vec=7 aborts without a done pulse
    startScan4(16'hFDA5, 1'b0);
    for (int i = 0; i < 100 && bus4.vec != 4'd7; i++) @(negedge clk);
    checkEq("abort_vec_reached", 32'(bus4.vec), 32'd7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkEq("abort_busy", 32'(bus4.busy), 32'd0);
    checkEq("abort_vec", 32'(bus4.vec), 32'd0);
    checkEq("abort_table", 32'(bus4.table_out), 32'd0);
    checkEq("abort_done", 32'(bus4.done), 32'd0);
    checkEq("abort_mcnt", 32'(bus4.mismatch_cnt), 32'd0);
    repeat (80) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

- Sequential stimulus/capture stage wrapped around one combinational Boolean-function block of the lab designs (3- or 4-input, single output).
- Drives the function's inputs through every input combination in ascending order and samples its output after a settle window.
- Assembles the 16-bit truth table and compares it with an expected table captured at start.
- Sits directly upstream (drives A..D) and downstream (consumes Y) of the function under test.

## Interface
- `NVARS`, default 4: number of function inputs, legal values 3 or 4. Number of vectors is N = 2^NVARS.
- `SETTLE`, default 2: extra cycles each vector is held before its output is sampled. Legal range 0..15.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a scan. Accepted only when `busy`=0.
- `expected`  in  16  expected truth table, bit i is the output for vector i. Captured on the accepted `start` cycle.
- `vec`  out  4  applied input vector.
  - NVARS=4: A=vec[3], B=vec[2], C=vec[1], D=vec[0].
  - NVARS=3: A=vec[2], B=vec[1], C=vec[0]; vec[3] is held at 0.
- `y`  in  1  function output, combinational from `vec`.
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle pulse when results are valid.
- `table_out`  out  16  captured truth table. Bits N..15 are 0.
- `pass`  out  1  1 when the captured table equals the expected table in bits 0..N-1.
- `mismatch_cnt`  out  5  number of mismatching bits, 0..16.
- `first_fail`  out  4  lowest mismatching index. 0 when no bit mismatches.

## Operation
- FSM states: IDLE, APPLY, DONE.
  - IDLE, `start`=1: capture `expected`; clear `table_out`, `mismatch_cnt`, `first_fail`, `pass`; vec=0; settle counter=0; go to APPLY.
  - APPLY, settle counter < SETTLE: increment the counter and hold `vec`.
  - APPLY, settle counter = SETTLE: sample `y` into `table_out[vec]`.
    - If y differs from `expected[vec]`: increment `mismatch_cnt`. If this is the first mismatch of the scan, load `first_fail`=vec.
    - If vec = N-1, go to DONE. Otherwise increment vec and clear the settle counter.
  - DONE: `done`=1 for exactly one cycle; `pass` = (`mismatch_cnt`==0); then go to IDLE.
    - A `start` during DONE is accepted: the FSM goes straight to APPLY as if from IDLE.
- `busy`=1 in APPLY only.
- `start` while `busy`=1 is ignored; there is no queuing.
- Bits of `expected` at index ≥ N are ignored.
- Results (`table_out`, `pass`, `mismatch_cnt`, `first_fail`) hold their values from DONE until the next accepted `start` or `rst`.
- `vec` returns to 0 on entering DONE.
- Mismatch accumulation is saturation-free: the maximum count of 16 fits in 5 bits.

## Timing
- Reset values, all outputs 0: vec=0, busy=0, done=0, table_out=0, pass=0, mismatch_cnt=0, first_fail=0. State resets to IDLE.
- `rst` mid-scan: on the next edge all outputs and state return to reset values. The aborted scan produces no `done`.
- Timing is measured from the accepted `start` at edge 0.
  - Edge 1 onward: `vec`=0 and `busy`=1.
  - Each vector is held for SETTLE+1 cycles and sampled on the last of them.
  - `done`=1 during the cycle after edge 1 + N·(SETTLE+1).
  - NVARS=4, SETTLE=2: done after edge 49.
  - NVARS=3, SETTLE=0: done after edge 9.
- `y` is sampled on the same edge that advances `vec`. Combinational settling of `y` therefore has at least SETTLE+1 cycles.
- `pass` updates in the same cycle `done` asserts.
- Back-to-back scans: `start` held high during DONE gives `busy`=1 on the very next cycle, with no IDLE cycle in between.

## Test plan
- Y4 = BD|AC|~B~D|AB, NVARS=4, SETTLE=2, expected=16'hFDA5, start pulse.
  - done after edge 49; table_out=16'hFDA5; pass=1; mismatch_cnt=0; first_fail=0.
- Y2 = ~B, NVARS=3, SETTLE=0, expected=16'h0033.
  - done after edge 9; table_out=16'h0033; pass=1; vec[3] stays 0 throughout.
- Same Y4 setup, expected=16'hFDA4.
  - pass=0; mismatch_cnt=1; first_fail=0.
- Same Y4 setup, expected=16'h0000.
  - mismatch_cnt=11; first_fail=0; table_out=16'hFDA5.
- Assert `rst` while vec=7 mid-scan.
  - Next cycle: busy=0, vec=0, table_out=0, and no done pulse.
- `start` re-pulsed while busy has no effect on timing.
- `start` held high through DONE.
  - A second scan begins immediately; its results equal the first scan's.
